// File: rtl/axi_slave_pkg.sv
// Shared constants and FSM state types for the AXI slave memory.
package axi_slave_pkg;

    // Burst types carried on awburst/arburst; 2'b11 is reserved.
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Response codes carried on bresp/rresp.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_e;

    // WRAP and the reserved encoding are the only types with bit 1 set.
    function automatic logic burst_is_bad(input logic [1:0] burst);
        return burst[1];
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle (AW/W/B/AR/R channels) between a master and the slave memory.
interface axi_slave_mem_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/axi_slave_mem_array.sv
// Word-addressed storage: one byte-enabled write port, one registered read port.
// A read and a write to the same word on the same edge return the old word.
module axi_slave_mem_array #(
    parameter int  DATA_WIDTH = 64,
    parameter int  MEM_DEPTH  = 256,
    localparam int AW         = $clog2(MEM_DEPTH),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Byte-lane write of the strobe-enabled bytes.
    // NOTE: the array has no reset -- contents survive rst_n, and a reset loop would
    // prevent the synthesis tool from mapping it onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    // NOTE: non-blocking here is what makes a same-edge read see the old word.
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register; only updates when a new beat is fetched so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 burst slave backed by a MEM_DEPTH x DATA_WIDTH memory.
// Independent write (WR_IDLE/WR_DATA/WR_RESP) and read (RD_IDLE/RD_DATA) FSMs.
// Every beat is full width; the low address bits below the word size are ignored.
// Optional macro AXI_SLAVE_ERR_CHECK_EN: out-of-range beats, WRAP/reserved bursts
// and wlast mismatches produce SLVERR; otherwise responses are always OKAY,
// WRAP behaves as INCR and the word index wraps modulo MEM_DEPTH.
module axi_slave_mem
    import axi_slave_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 256
) (
    input logic            clk,
    input logic            rst_n,
    axi_slave_mem_if.slave bus
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;
    localparam int AW     = $clog2(MEM_DEPTH);

    // Word index of the beat after idx; the full-width index is kept so range
    // overflow stays visible, and the array only sees the low AW bits.
    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                    input logic [1:0]       burst);
        return (burst == BURST_FIXED) ? idx : idx + IDX_W'(1);
    endfunction

`ifdef AXI_SLAVE_ERR_CHECK_EN
    function automatic logic beat_bad(input logic [IDX_W-1:0] idx, input logic [1:0] burst);
        return burst_is_bad(burst) || ((idx >> AW) != '0);
    endfunction
`endif

    // ---------------------------------------------------------------- write side
    wr_state_e             wr_state, wr_next;
    logic                  awready_q;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [IDX_W-1:0]      wr_idx;
    logic [7:0]            wr_len, wr_cnt;
    logic [1:0]            wr_burst;
    logic                  aw_hs, w_hs, wr_last_beat, wr_beat_bad, mem_we;

    assign aw_hs        = bus.awvalid && awready_q;
    assign w_hs         = bus.wvalid && (wr_state == WR_DATA);
    assign wr_last_beat = (wr_cnt == wr_len);

`ifdef AXI_SLAVE_ERR_CHECK_EN
    logic wr_err;
    logic wr_beat_err;
    assign wr_beat_bad = beat_bad(wr_idx, wr_burst);
    assign wr_beat_err = wr_beat_bad || (bus.wlast != wr_last_beat);
    assign bus.bresp   = ((wr_state == WR_RESP) && wr_err) ? RESP_SLVERR : RESP_OKAY;
`else
    assign wr_beat_bad = 1'b0;
    assign bus.bresp   = RESP_OKAY;
`endif

    assign mem_we      = w_hs && !wr_beat_bad;
    assign bus.awready = awready_q;
    assign bus.bid     = wr_id;

    // Write FSM next state and per-state handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        wr_next    = wr_state;
        bus.wready = 1'b0;
        bus.bvalid = 1'b0;
        unique case (wr_state)
            WR_IDLE: begin
                if (aw_hs) wr_next = WR_DATA;
            end
            WR_DATA: begin
                bus.wready = 1'b1;
                if (w_hs && wr_last_beat) wr_next = WR_RESP;
            end
            WR_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Write state, registered awready, and burst context latched at AW / stepped per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state  <= WR_IDLE;
            awready_q <= 1'b0;
            wr_id     <= '0;
            wr_idx    <= '0;
            wr_len    <= '0;
            wr_cnt    <= '0;
            wr_burst  <= BURST_FIXED;
`ifdef AXI_SLAVE_ERR_CHECK_EN
            wr_err    <= 1'b0;
`endif
        end else begin
            wr_state  <= wr_next;
            awready_q <= (wr_next == WR_IDLE);
            if (aw_hs) begin
                wr_id    <= bus.awid;
                wr_idx   <= bus.awaddr[ADDR_WIDTH-1:OFF_W];
                wr_len   <= bus.awlen;
                wr_burst <= bus.awburst;
                wr_cnt   <= '0;
`ifdef AXI_SLAVE_ERR_CHECK_EN
                wr_err   <= 1'b0;
`endif
            end else if (w_hs) begin
                wr_cnt   <= wr_cnt + 8'd1;
                wr_idx   <= next_index(wr_idx, wr_burst);
`ifdef AXI_SLAVE_ERR_CHECK_EN
                wr_err   <= wr_err || wr_beat_err;
`endif
            end
        end
    end

    // ----------------------------------------------------------------- read side
    rd_state_e             rd_state, rd_next;
    logic                  arready_q;
    logic [ID_WIDTH-1:0]   rd_id;
    logic [IDX_W-1:0]      rd_idx, rd_idx_nx, ar_idx, rd_fetch_idx;
    logic [7:0]            rd_len, rd_cnt;
    logic [1:0]            rd_burst;
    logic                  ar_hs, r_hs, rd_last_beat, rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign ar_hs        = bus.arvalid && arready_q;
    assign r_hs         = (rd_state == RD_DATA) && bus.rready;
    assign rd_last_beat = (rd_cnt == rd_len);
    assign ar_idx       = bus.araddr[ADDR_WIDTH-1:OFF_W];
    assign rd_idx_nx    = next_index(rd_idx, rd_burst);
    // Fetch the first beat on AR, and the next beat on every non-final R handshake.
    assign rd_en        = ar_hs || (r_hs && !rd_last_beat);
    assign rd_fetch_idx = ar_hs ? ar_idx : rd_idx_nx;

    assign bus.arready  = arready_q;
    assign bus.rid      = rd_id;

`ifdef AXI_SLAVE_ERR_CHECK_EN
    logic       rd_beat_bad;
    logic [1:0] rd_fetch_burst;
    assign rd_fetch_burst = ar_hs ? bus.arburst : rd_burst;
    assign bus.rdata      = rd_beat_bad ? '0 : mem_rdata;
    assign bus.rresp      = rd_beat_bad ? RESP_SLVERR : RESP_OKAY;
`else
    assign bus.rdata      = mem_rdata;
    assign bus.rresp      = RESP_OKAY;
`endif

    // Read FSM next state and beat-valid outputs.
    always_comb begin
        rd_next    = rd_state;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        unique case (rd_state)
            RD_IDLE: begin
                if (ar_hs) rd_next = RD_DATA;
            end
            RD_DATA: begin
                bus.rvalid = 1'b1;
                bus.rlast  = rd_last_beat;
                if (r_hs && rd_last_beat) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read state, registered arready, and burst context latched at AR / stepped per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state    <= RD_IDLE;
            arready_q   <= 1'b0;
            rd_id       <= '0;
            rd_idx      <= '0;
            rd_len      <= '0;
            rd_cnt      <= '0;
            rd_burst    <= BURST_FIXED;
`ifdef AXI_SLAVE_ERR_CHECK_EN
            rd_beat_bad <= 1'b0;
`endif
        end else begin
            rd_state  <= rd_next;
            arready_q <= (rd_next == RD_IDLE);
            if (ar_hs) begin
                rd_id    <= bus.arid;
                rd_idx   <= ar_idx;
                rd_len   <= bus.arlen;
                rd_burst <= bus.arburst;
                rd_cnt   <= '0;
            end else if (r_hs && !rd_last_beat) begin
                rd_idx   <= rd_idx_nx;
                rd_cnt   <= rd_cnt + 8'd1;
            end
`ifdef AXI_SLAVE_ERR_CHECK_EN
            if (rd_en) rd_beat_bad <= beat_bad(rd_fetch_idx, rd_fetch_burst);
`endif
        end
    end

    axi_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_idx[AW-1:0]),
        .wstrb (bus.wstrb),
        .wdata (bus.wdata),
        .re    (rd_en),
        .raddr (rd_fetch_idx[AW-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem (default 64-bit data, 256 words).
// Expected values follow AXI_SLAVE_ERR_CHECK_EN when the macro is defined.
module tb_axi_slave_mem;

    localparam int ID_W = 4;
    localparam int A_W  = 32;
    localparam int D_W  = 64;
    localparam int DEP  = 256;

`ifdef AXI_SLAVE_ERR_CHECK_EN
    localparam logic [1:0]  EXP_ERR   = 2'b10;
    localparam logic [63:0] EXP_WORD0 = 64'hFFFF_FFFF_0000_0000;
`else
    localparam logic [1:0]  EXP_ERR   = 2'b00;
    localparam logic [63:0] EXP_WORD0 = 64'hD1;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    axi_slave_mem_if #(.ID_WIDTH(ID_W), .ADDR_WIDTH(A_W), .DATA_WIDTH(D_W)) bus ();

    axi_slave_mem #(
        .ID_WIDTH   (ID_W),
        .ADDR_WIDTH (A_W),
        .DATA_WIDTH (D_W),
        .MEM_DEPTH  (DEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
        bus.awvalid = 1'b1;
        while (!bus.awready && n < 20) begin tick(); n++; end
        check("aw_ready", bus.awready, 1'b1);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic last);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1'b1;
        while (!bus.wready && n < 20) begin tick(); n++; end
        check("w_ready", bus.wready, 1'b1);
        tick();
        bus.wvalid = 1'b0;
    endtask

    task automatic b_wait(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        bus.bready = 1'b1;
        while (!bus.bvalid && n < 20) begin tick(); n++; end
        check({tag, "_bvalid"}, bus.bvalid, 1'b1);
        check({tag, "_bid"}, bus.bid, id);
        check({tag, "_bresp"}, bus.bresp, resp);
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 20) begin tick(); n++; end
        check("ar_ready", bus.arready, 1'b1);
        tick();
        bus.arvalid = 1'b0;
    endtask

    task automatic r_recv(input string tag, input logic [63:0] d, input logic last,
                          input logic [1:0] resp, input bit chk_data);
        int n = 0;
        bus.rready = 1'b1;
        while (!bus.rvalid && n < 20) begin tick(); n++; end
        check({tag, "_rvalid"}, bus.rvalid, 1'b1);
        if (chk_data) check({tag, "_rdata"}, bus.rdata, d);
        check({tag, "_rlast"}, bus.rlast, last);
        check({tag, "_rresp"}, bus.rresp, resp);
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // Reset values held while rst_n is low.
        repeat (3) tick();
        check("rst_awready", bus.awready, 1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_wready",  bus.wready,  1'b0);
        check("rst_bvalid",  bus.bvalid,  1'b0);
        check("rst_rvalid",  bus.rvalid,  1'b0);
        check("rst_rlast",   bus.rlast,   1'b0);
        check("rst_bresp",   bus.bresp,   2'b00);
        check("rst_rresp",   bus.rresp,   2'b00);
        check("rst_bid",     bus.bid,     4'h0);
        check("rst_rid",     bus.rid,     4'h0);
        check("rst_rdata",   bus.rdata,   64'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_awready", bus.awready, 1'b1);
        check("post_rst_arready", bus.arready, 1'b1);

        // INCR write of four words at 0x40, then read them back.
        aw_send(4'h1, 32'h40, 8'd3, 2'b01);
        check("aw_drop_awready", bus.awready, 1'b0);
        w_send(64'h11, 8'hFF, 1'b0);
        w_send(64'h22, 8'hFF, 1'b0);
        w_send(64'h33, 8'hFF, 1'b0);
        w_send(64'h44, 8'hFF, 1'b1);
        check("incr_bvalid_next", bus.bvalid, 1'b1);
        b_wait("incr", 4'h1, 2'b00);
        check("incr_awready_back", bus.awready, 1'b1);
        check("incr_bvalid_drop", bus.bvalid, 1'b0);

        ar_send(4'h2, 32'h40, 8'd3, 2'b01);
        check("rd_first_rvalid", bus.rvalid, 1'b1);
        check("rd_rid", bus.rid, 4'h2);
        r_recv("rd0", 64'h11, 1'b0, 2'b00, 1'b1);
        r_recv("rd1", 64'h22, 1'b0, 2'b00, 1'b1);
        r_recv("rd2", 64'h33, 1'b0, 2'b00, 1'b1);
        r_recv("rd3", 64'h44, 1'b1, 2'b00, 1'b1);
        check("rd_end_rvalid", bus.rvalid, 1'b0);
        check("rd_end_arready", bus.arready, 1'b1);

        // Same-edge read and write of word 8: read returns the old 0x11.
        aw_send(4'h3, 32'h40, 8'd0, 2'b01);
        bus.wdata = 64'h99; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        bus.arid = 4'h4; bus.araddr = 32'h40; bus.arlen = 8'd0; bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        check("coll_wready", bus.wready, 1'b1);
        check("coll_arready", bus.arready, 1'b1);
        tick();
        bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        r_recv("coll_rd", 64'h11, 1'b1, 2'b00, 1'b1);
        b_wait("coll", 4'h3, 2'b00);
        ar_send(4'h4, 32'h40, 8'd0, 2'b01);
        r_recv("coll_new", 64'h99, 1'b1, 2'b00, 1'b1);

        // Partial strobe: only the low four bytes are overwritten.
        aw_send(4'h1, 32'h0, 8'd0, 2'b01);
        w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        b_wait("full", 4'h1, 2'b00);
        aw_send(4'h1, 32'h0, 8'd0, 2'b01);
        w_send(64'h0, 8'h0F, 1'b1);
        b_wait("part", 4'h1, 2'b00);
        ar_send(4'h1, 32'h0, 8'd0, 2'b01);
        r_recv("strb", 64'hFFFF_FFFF_0000_0000, 1'b1, 2'b00, 1'b1);

        // FIXED burst keeps hitting word 32; word 33 keeps 0x55.
        aw_send(4'h9, 32'h108, 8'd0, 2'b01);
        w_send(64'h55, 8'hFF, 1'b1);
        b_wait("w33", 4'h9, 2'b00);
        aw_send(4'h9, 32'h100, 8'd2, 2'b00);
        w_send(64'hE0, 8'hFF, 1'b0);
        w_send(64'hE1, 8'hFF, 1'b0);
        w_send(64'hE2, 8'hFF, 1'b1);
        b_wait("fixed", 4'h9, 2'b00);
        ar_send(4'h9, 32'h100, 8'd1, 2'b01);
        r_recv("fixed_w32", 64'hE2, 1'b0, 2'b00, 1'b1);
        r_recv("fixed_w33", 64'h55, 1'b1, 2'b00, 1'b1);
        ar_send(4'h9, 32'h100, 8'd1, 2'b00);
        r_recv("fixed_rd0", 64'hE2, 1'b0, 2'b00, 1'b1);
        r_recv("fixed_rd1", 64'hE2, 1'b1, 2'b00, 1'b1);

        // Eight-beat write with bready held low for five cycles.
        aw_send(4'h5, 32'h200, 8'd7, 2'b01);
        for (int i = 0; i < 8; i++) w_send(64'hB0 + 64'(i), 8'hFF, i == 7);
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid_hold", bus.bvalid, 1'b1);
            check("bp_bid_hold", bus.bid, 4'h5);
            check("bp_awready_low", bus.awready, 1'b0);
            tick();
        end
        b_wait("bp", 4'h5, 2'b00);

        // Eight-beat read with rready toggling every cycle.
        ar_send(4'h6, 32'h200, 8'd7, 2'b01);
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            bus.rready = cyc[0];
            if (bus.rvalid) begin
                check("bp_rdata", bus.rdata, 64'hB0 + 64'(k));
                check("bp_rlast", bus.rlast, k == 7);
            end
            if (bus.rvalid && bus.rready) k++;
            tick();
        end
        bus.rready = 1'b0;
        check("bp_beats", k, 8);
        check("bp_rvalid_end", bus.rvalid, 1'b0);

        // Early and missing wlast: data still written.
        aw_send(4'h6, 32'h500, 8'd1, 2'b01);
        w_send(64'hC0, 8'hFF, 1'b1);
        w_send(64'hC1, 8'hFF, 1'b0);
        b_wait("wlast", 4'h6, EXP_ERR);
        ar_send(4'h6, 32'h500, 8'd1, 2'b01);
        r_recv("wlast0", 64'hC0, 1'b0, 2'b00, 1'b1);
        r_recv("wlast1", 64'hC1, 1'b1, 2'b00, 1'b1);

        // Burst starting at the last word: second beat wraps to word 0 or is suppressed.
        aw_send(4'h7, (DEP - 1) * 8, 8'd1, 2'b01);
        w_send(64'hD0, 8'hFF, 1'b0);
        w_send(64'hD1, 8'hFF, 1'b1);
        b_wait("top", 4'h7, EXP_ERR);
        ar_send(4'h7, (DEP - 1) * 8, 8'd0, 2'b01);
        r_recv("top_last", 64'hD0, 1'b1, 2'b00, 1'b1);
        ar_send(4'h7, 32'h0, 8'd0, 2'b01);
        r_recv("top_word0", EXP_WORD0, 1'b1, 2'b00, 1'b1);

        // WRAP read: INCR behaviour by default, SLVERR on every beat with checking on.
        ar_send(4'h8, 32'h40, 8'd1, 2'b10);
`ifdef AXI_SLAVE_ERR_CHECK_EN
        r_recv("wrap0", 64'h0, 1'b0, 2'b10, 1'b0);
        r_recv("wrap1", 64'h0, 1'b1, 2'b10, 1'b0);
`else
        r_recv("wrap0", 64'h99, 1'b0, 2'b00, 1'b1);
        r_recv("wrap1", 64'h22, 1'b1, 2'b00, 1'b1);
`endif

        // Reset during beat 2 of a four-beat write.
        aw_send(4'hA, 32'h300, 8'd3, 2'b01);
        w_send(64'hA0, 8'hFF, 1'b0);
        w_send(64'hA1, 8'hFF, 1'b0);
        bus.wdata = 64'hA2; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wready", bus.wready, 1'b0);
        check("mid_rst_bvalid", bus.bvalid, 1'b0);
        check("mid_rst_awready", bus.awready, 1'b0);
        bus.wvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_awready_up", bus.awready, 1'b1);
        check("mid_rst_no_bvalid", bus.bvalid, 1'b0);
        ar_send(4'hA, 32'h300, 8'd1, 2'b01);
        r_recv("mid_rst_b0", 64'hA0, 1'b0, 2'b00, 1'b1);
        r_recv("mid_rst_b1", 64'hA1, 1'b1, 2'b00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
